// File: rtl/pwm_cfg_ctrl.sv
// pwm_cfg_ctrl: parses framed command packets from a UART byte stream and
// updates the PWM compare values and the channel enable mask.
//
// Packet: SYNC(0xA5), CMD (opcode[7:4] / channel[3:0]), optional DATA, CHK.
// CHK = CMD ^ DATA, or CMD alone when the packet carries no DATA.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   rx_valid/rx_data  received byte strobe and value
//   rx_err            receiver framing/parity error strobe
//   compare_o         8-bit compare value per channel, channel n at [8n+7:8n]
//   enable_o          per-channel enable mask
//   busy_o            packet in progress
//   cmd_ok_o          one-cycle pulse, packet applied
//   cmd_err_o         one-cycle pulse, packet rejected
//   err_code_o        most recent error code (held)
//   err_count_o       rejected packet count, saturating at 255
module pwm_cfg_ctrl #(
    parameter int unsigned NUM_CH         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TIMEOUT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_err,
    output logic [NUM_CH*8-1:0]   compare_o,
    output logic [NUM_CH-1:0]     enable_o,
    output logic                  busy_o,
    output logic                  cmd_ok_o,
    output logic                  cmd_err_o,
    output logic [2:0]            err_code_o,
    output logic [7:0]            err_count_o
);

    localparam int unsigned CMP_W = NUM_CH * 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_CHK  = 2'd3;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [3:0] OP_CLEAR   = 4'h0;
    localparam logic [3:0] OP_SET_CMP = 4'h1;
    localparam logic [3:0] OP_SET_EN  = 4'h2;

    localparam logic [2:0] E_OPCODE   = 3'd1;
    localparam logic [2:0] E_CHECKSUM = 3'd2;
    localparam logic [2:0] E_CHANNEL  = 3'd3;
    localparam logic [2:0] E_FRAME    = 3'd4;
    localparam logic [2:0] E_TIMEOUT  = 3'd5;

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    logic [1:0]               state_q, state_d;
    logic [7:0]               cmd_q, cmd_d;
    logic [7:0]               data_q, data_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic [CMP_W-1:0]         compare_q, compare_d;
    logic [NUM_CH-1:0]        enable_q, enable_d;
    logic                     busy_q, busy_d;
    logic                     ok_q, ok_d;
    logic                     err_q, err_d;
    logic [2:0]               code_q, code_d;
    logic [7:0]               count_q, count_d;

    logic                     byte_ok;
    logic                     timeout_hit;
    logic                     raise;
    logic [2:0]               raise_code;

    // Next-state, datapath and pulse generation
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        tmo_d      = tmo_q;
        compare_d  = compare_q;
        enable_d   = enable_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        code_d     = code_q;
        count_d    = count_q;
        raise      = 1'b0;
        raise_code = 3'd0;

        // rx_err always discards a coincident byte
        byte_ok     = rx_valid && !rx_err;
        timeout_hit = (state_q != S_IDLE) && (tmo_q == TMO_LIMIT);

        if (timeout_hit) begin
            // The packet is dropped; a byte in this cycle is seen as if in IDLE
            raise      = 1'b1;
            raise_code = E_TIMEOUT;
            tmo_d      = '0;
            state_d    = (byte_ok && rx_data == SYNC_BYTE) ? S_CMD : S_IDLE;
        end else if (state_q != S_IDLE && rx_err) begin
            raise      = 1'b1;
            raise_code = E_FRAME;
            tmo_d      = '0;
            state_d    = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tmo_d = '0;
                    if (byte_ok && rx_data == SYNC_BYTE) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    if (byte_ok) begin
                        tmo_d  = '0;
                        cmd_d  = rx_data;
                        data_d = 8'h00;
                        case (rx_data[7:4])
                            OP_CLEAR:              state_d = S_CHK;
                            OP_SET_CMP, OP_SET_EN: state_d = S_DATA;
                            default: begin
                                raise      = 1'b1;
                                raise_code = E_OPCODE;
                                state_d    = S_IDLE;
                            end
                        endcase
                    end else begin
                        tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (byte_ok) begin
                        tmo_d   = '0;
                        data_d  = rx_data;
                        state_d = S_CHK;
                    end else begin
                        tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
                    end
                end
                default: begin
                    if (byte_ok) begin
                        tmo_d   = '0;
                        state_d = S_IDLE;
                        if (rx_data != (cmd_q ^ data_q)) begin
                            raise      = 1'b1;
                            raise_code = E_CHECKSUM;
                        end else if (cmd_q[7:4] == OP_SET_CMP &&
                                     {1'b0, cmd_q[3:0]} >= 5'(NUM_CH)) begin
                            raise      = 1'b1;
                            raise_code = E_CHANNEL;
                        end else begin
                            ok_d = 1'b1;
                            case (cmd_q[7:4])
                                OP_CLEAR: begin
                                    compare_d = '0;
                                    enable_d  = '0;
                                end
                                OP_SET_CMP: begin
                                    for (int unsigned n = 0; n < NUM_CH; n++) begin
                                        if (cmd_q[3:0] == 4'(n)) begin
                                            compare_d[8*n +: 8] = data_q;
                                        end
                                    end
                                end
                                default: begin
                                    enable_d = NUM_CH'({8'h00, data_q});
                                end
                            endcase
                        end
                    end else begin
                        tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
                    end
                end
            endcase
        end

        if (raise) begin
            err_d  = 1'b1;
            code_d = raise_code;
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= 8'h00;
            data_q    <= 8'h00;
            tmo_q     <= '0;
            compare_q <= '0;
            enable_q  <= '0;
            busy_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 3'd0;
            count_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            tmo_q     <= tmo_d;
            compare_q <= compare_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            code_q    <= code_d;
            count_q   <= count_d;
        end
    end

    assign compare_o   = compare_q;
    assign enable_o    = enable_q;
    assign busy_o      = busy_q;
    assign cmd_ok_o    = ok_q;
    assign cmd_err_o   = err_q;
    assign err_code_o  = code_q;
    assign err_count_o = count_q;

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// Bench for pwm_cfg_ctrl: byte-queue packet model, per-cycle comparison,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pwm_cfg_ctrl;

    localparam int unsigned NCH = 8;
    localparam int unsigned T   = 20;

    logic              clk;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_err;
    logic [NCH*8-1:0]  compare_o;
    logic [NCH-1:0]    enable_o;
    logic              busy_o;
    logic              cmd_ok_o;
    logic              cmd_err_o;
    logic [2:0]        err_code_o;
    logic [7:0]        err_count_o;

    pwm_cfg_ctrl #(
        .NUM_CH(NCH),
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_err(rx_err),
        .compare_o(compare_o),
        .enable_o(enable_o),
        .busy_o(busy_o),
        .cmd_ok_o(cmd_ok_o),
        .cmd_err_o(cmd_err_o),
        .err_code_o(err_code_o),
        .err_count_o(err_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Model: bytes of the packet collected so far, plus idle-gap counter
    logic [7:0]        pkt[$];
    int                gap;
    logic [NCH*8-1:0]  m_cmp;
    logic [7:0]        m_en;
    bit                m_ok;
    bit                m_err;
    logic [2:0]        m_code;
    int                m_cnt;
    bit                m_busy;

    function automatic void m_fail(input int code);
        m_err  = 1'b1;
        m_code = 3'(code);
        if (m_cnt < 255) m_cnt++;
        pkt.delete();
    endfunction

    function automatic void m_eval();
        logic [7:0] c;
        logic [7:0] x;
        int         need;
        c    = pkt[1];
        need = (c[7:4] == 4'h0) ? 3 : 4;
        if (c[7:4] > 4'h2) begin
            m_fail(1);
        end else if (pkt.size() == need) begin
            x = 8'h00;
            for (int i = 1; i < need - 1; i++) x = x ^ pkt[i];
            if (x != pkt[need-1]) begin
                m_fail(2);
            end else if (c[7:4] == 4'h1 && int'(c[3:0]) >= NCH) begin
                m_fail(3);
            end else begin
                m_ok = 1'b1;
                if (c[7:4] == 4'h0) begin
                    m_cmp = '0;
                    m_en  = 8'h00;
                end else if (c[7:4] == 4'h1) begin
                    m_cmp[int'(c[3:0])*8 +: 8] = pkt[2];
                end else begin
                    m_en = pkt[2];
                end
                pkt.delete();
            end
        end
    endfunction

    function automatic void model_step(input bit r, input bit v,
                                       input logic [7:0] d, input bit e);
        bit acc;
        bit was_busy;
        if (r) begin
            pkt.delete();
            gap = 0; m_cmp = '0; m_en = 8'h00; m_ok = 0; m_err = 0;
            m_code = 3'd0; m_cnt = 0; m_busy = 0;
            return;
        end
        m_ok     = 1'b0;
        m_err    = 1'b0;
        acc      = v && !e;
        was_busy = pkt.size() > 0;
        if (was_busy && gap == int'(T)) begin
            m_fail(5);
            if (acc && d == 8'hA5) pkt.push_back(d);
        end else if (was_busy && e) begin
            m_fail(4);
        end else if (acc) begin
            if (!was_busy) begin
                if (d == 8'hA5) pkt.push_back(d);
            end else begin
                pkt.push_back(d);
                m_eval();
            end
        end
        if (pkt.size() == 0 || acc) gap = 0;
        else gap++;
        m_busy = pkt.size() > 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("compare_o",   64'(compare_o),   64'(m_cmp));
        check("enable_o",    64'(enable_o),    64'(m_en));
        check("busy_o",      64'(busy_o),      64'(m_busy));
        check("cmd_ok_o",    64'(cmd_ok_o),    64'(m_ok));
        check("cmd_err_o",   64'(cmd_err_o),   64'(m_err));
        check("err_code_o",  64'(err_code_o),  64'(m_code));
        check("err_count_o", 64'(err_count_o), 64'(m_cnt));
    endtask

    task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit e);
        reset    = r;
        rx_valid = v;
        rx_data  = d;
        rx_err   = e;
        @(posedge clk);
        model_step(r, v, d, e);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
        logic [7:0] cmd;
        logic [7:0] dat;
        logic [7:0] chk;
        int         sel;
        int         op;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_err   = 1'b0;
        @(negedge clk);

        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_compare", 64'(compare_o), 64'h0);
        check("rst_count",   64'(err_count_o), 64'h0);

        // Partial packet: busy, nothing applied yet
        send(8'hA5); send(8'h13);
        check("partial_busy", 64'(busy_o), 64'h1);
        send(8'h40); send(8'h53);
        check("setcmp_ch3", 64'(compare_o[31:24]), 64'h40);
        check("setcmp_ok",  64'(cmd_ok_o), 64'h1);
        check("setcmp_idle", 64'(busy_o), 64'h0);
        idle(1);
        check("ok_one_pulse", 64'(cmd_ok_o), 64'h0);

        send(8'hA5); send(8'h20); send(8'hF5); send(8'hD5);
        check("set_en", 64'(enable_o), 64'hF5);
        send(8'hA5); send(8'h00); send(8'h00);
        check("clear_cmp", 64'(compare_o), 64'h0);
        check("clear_en",  64'(enable_o), 64'h0);

        send(8'hA5); send(8'h13); send(8'h40); send(8'h00);
        check("bad_chk_code", 64'(err_code_o), 64'h2);
        check("bad_chk_cnt",  64'(err_count_o), 64'h1);
        check("bad_chk_cmp",  64'(compare_o), 64'h0);
        send(8'hA5); send(8'h1A); send(8'h11); send(8'h0B);
        check("bad_ch_code", 64'(err_code_o), 64'h3);
        check("bad_ch_cnt",  64'(err_count_o), 64'h2);

        send(8'hA5); send(8'h70);
        check("opcode_err",  64'(cmd_err_o), 64'h1);
        check("opcode_code", 64'(err_code_o), 64'h1);
        check("opcode_idle", 64'(busy_o), 64'h0);
        send(8'hA5); send(8'h11); send(8'h22); send(8'h33);
        check("ch1_cmp", 64'(compare_o[15:8]), 64'h22);

        // Timeout fires on the (T+1)th silent cycle
        send(8'hA5); send(8'h11);
        idle(int'(T));
        check("pre_timeout_busy", 64'(busy_o), 64'h1);
        idle(1);
        check("timeout_code", 64'(err_code_o), 64'h5);
        check("timeout_idle", 64'(busy_o), 64'h0);

        send(8'hA5); send(8'h11);
        cyc(1'b0, 1'b1, 8'h22, 1'b1);
        check("frame_code", 64'(err_code_o), 64'h4);
        check("frame_cnt",  64'(err_count_o), 64'h5);

        // Back-to-back packets with SYNC right after CHK
        send(8'hA5); send(8'h12); send(8'h09); send(8'h1B);
        send(8'hA5); send(8'h00); send(8'h00);
        check("b2b_clear", 64'(compare_o), 64'h0);

        for (int i = 0; i < 256; i++) begin
            send(8'hA5); send(8'h70);
        end
        check("sat_count", 64'(err_count_o), 64'hFF);

        send(8'hA5); send(8'h11);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        check("midrst_count", 64'(err_count_o), 64'h0);
        check("midrst_busy",  64'(busy_o), 64'h0);
        idle(2);

        // Randomized traffic
        for (int p = 0; p < 500; p++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 3) begin
                cyc(1'b1, 1'b0, 8'h00, 1'b0);
            end else if (sel < 8) begin
                cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
            end else begin
                op = int'($urandom_range(0, 9));
                if (op <= 2)      cmd[7:4] = 4'h0;
                else if (op <= 6) cmd[7:4] = 4'h1;
                else if (op <= 8) cmd[7:4] = 4'h2;
                else              cmd[7:4] = 4'($urandom_range(3, 15));
                cmd[3:0] = 4'($urandom_range(0, 9));
                dat = 8'($urandom);
                chk = (cmd[7:4] == 4'h0) ? cmd : (cmd ^ dat);
                if ($urandom_range(0, 9) == 0) chk = chk ^ 8'($urandom_range(1, 255));
                send(8'hA5);
                for (int b = 0; b < 3; b++) begin
                    sel = int'($urandom_range(0, 99));
                    if (sel < 4)      idle(int'($urandom_range(T - 1, T + 1)));
                    else if (sel < 7) cyc(1'b0, $urandom_range(0, 1) == 1, 8'($urandom), 1'b1);
                    else if (sel < 30) idle(int'($urandom_range(1, 3)));
                    if (b == 0) send(cmd);
                    else if (b == 1 && cmd[7:4] != 4'h0) send(dat);
                    else if (b == 2 || (b == 1 && cmd[7:4] == 4'h0)) begin
                        send(chk);
                        break;
                    end
                end
                if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 2)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
